// File: rtl/cipo_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : cipo_deserializer
// Brief    : Recovers 16-bit words from two SPI CIPO lines, sampling a
//            programmable number of cycles after each SCLK strobe.
//            Define CIPO_DDR_EN to also capture falling-edge samples.
// Revision : 1.0 - initial release
// ============================================================================
module cipo_deserializer #(
    parameter int WORD_BITS = 16,
    parameter int MAX_DELAY = 15
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cipo0,
    input  logic                             cipo1,
    input  logic                             frame_start,
    input  logic                             sclk_rise,
    input  logic                             sclk_fall,
    input  logic [$clog2(MAX_DELAY+1)-1:0]   delay,
    output logic [WORD_BITS-1:0]             word0_a,
    output logic [WORD_BITS-1:0]             word1_a,
    output logic [WORD_BITS-1:0]             word0_b,
    output logic [WORD_BITS-1:0]             word1_b,
    output logic                             word_valid,
    input  logic                             word_ready,
    output logic                             overrun,
    output logic                             framing_err,
    input  logic                             err_clr
);

    localparam int c_tap_w = $clog2(MAX_DELAY + 1);
    localparam int c_cnt_w = $clog2(WORD_BITS + 1);
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(WORD_BITS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_DELIVER = 2'd2
    } state_t;

    state_t r_state;

    // ---------------- input synchronizer ----------------
    logic [1:0] r_cipo0_sync;
    logic [1:0] r_cipo1_sync;
    logic       w_cipo0_s;
    logic       w_cipo1_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cipo0_sync <= 2'b00;
            r_cipo1_sync <= 2'b00;
        end else begin
            r_cipo0_sync <= {r_cipo0_sync[0], cipo0};
            r_cipo1_sync <= {r_cipo1_sync[0], cipo1};
        end
    end

    assign w_cipo0_s = r_cipo0_sync[1];
    assign w_cipo1_s = r_cipo1_sync[1];

    // ---------------- strobe delay lines ----------------
    // Index 0 of each line is the live strobe, index k is the strobe k cycles ago.
    logic [MAX_DELAY-1:0] r_tag_start;
    logic [MAX_DELAY-1:0] r_tag_rise;
    logic [MAX_DELAY:0]   w_line_start;
    logic [MAX_DELAY:0]   w_line_rise;
    logic [c_tap_w-1:0]   r_tap;
    logic [c_tap_w-1:0]   w_tap;
    logic                 w_d_start;
    logic                 w_d_rise;
    logic                 w_d_fall;

    // A new frame uses the delay presented with its own frame_start, so a
    // zero-delay start is not missed while the old tap is still selected.
    assign w_tap        = frame_start ? delay : r_tap;
    assign w_line_start = {r_tag_start, frame_start};
    assign w_line_rise  = {r_tag_rise, sclk_rise};
    assign w_d_start    = w_line_start[w_tap];
    assign w_d_rise     = w_line_rise[w_tap];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_start <= '0;
            r_tag_rise  <= '0;
            r_tap       <= '0;
        end else begin
            r_tag_start <= w_line_start[MAX_DELAY-1:0];
            r_tag_rise  <= w_line_rise[MAX_DELAY-1:0];
            if (frame_start) begin
                r_tap <= delay;
            end
        end
    end

`ifdef CIPO_DDR_EN
    logic [MAX_DELAY-1:0] r_tag_fall;
    logic [MAX_DELAY:0]   w_line_fall;

    assign w_line_fall = {r_tag_fall, sclk_fall};
    assign w_d_fall    = w_line_fall[w_tap];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_fall <= '0;
        end else begin
            r_tag_fall <= w_line_fall[MAX_DELAY-1:0];
        end
    end
`else
    logic w_unused_fall;

    assign w_unused_fall = sclk_fall;
    assign w_d_fall      = 1'b0;
`endif

    // ---------------- shift registers and bit counters ----------------
    logic [WORD_BITS-1:0] r_sh0_a;
    logic [WORD_BITS-1:0] r_sh1_a;
    logic [WORD_BITS-1:0] r_sh0_b;
    logic [WORD_BITS-1:0] r_sh1_b;
    logic [c_cnt_w-1:0]   r_rcnt;
    logic [c_cnt_w-1:0]   r_fcnt;
    logic [c_cnt_w-1:0]   w_rcnt_next;
    logic [c_cnt_w-1:0]   w_fcnt_next;
    logic                 w_rise_take;
    logic                 w_fall_take;
    logic                 w_done;

    assign w_rise_take = (r_state == ST_SHIFT) && w_d_rise && (r_rcnt < c_full);
    assign w_fall_take = (r_state == ST_SHIFT) && w_d_fall && (r_fcnt < c_full);
    assign w_rcnt_next = r_rcnt + c_cnt_w'(w_rise_take);
    assign w_fcnt_next = r_fcnt + c_cnt_w'(w_fall_take);

`ifdef CIPO_DDR_EN
    assign w_done = (r_state == ST_SHIFT) && !w_d_start &&
                    (w_rcnt_next == c_full) && (w_fcnt_next == c_full);
`else
    assign w_done = (r_state == ST_SHIFT) && !w_d_start && (w_rcnt_next == c_full);
`endif

    // Any delayed start, in any state, begins a fresh frame.
    always_ff @(posedge clk) begin
        if (rst || w_d_start) begin
            r_sh0_a <= '0;
            r_sh1_a <= '0;
            r_sh0_b <= '0;
            r_sh1_b <= '0;
            r_rcnt  <= '0;
            r_fcnt  <= '0;
        end else begin
            if (w_rise_take) begin
                r_sh0_a <= {r_sh0_a[WORD_BITS-2:0], w_cipo0_s};
                r_sh1_a <= {r_sh1_a[WORD_BITS-2:0], w_cipo1_s};
            end
            if (w_fall_take) begin
                r_sh0_b <= {r_sh0_b[WORD_BITS-2:0], w_cipo0_s};
                r_sh1_b <= {r_sh1_b[WORD_BITS-2:0], w_cipo1_s};
            end
            r_rcnt <= w_rcnt_next;
            r_fcnt <= w_fcnt_next;
        end
    end

    // ---------------- control FSM and output registers ----------------
    logic [WORD_BITS-1:0] r_word0_a;
    logic [WORD_BITS-1:0] r_word1_a;
    logic [WORD_BITS-1:0] r_word0_b;
    logic [WORD_BITS-1:0] r_word1_b;
    logic                 r_word_valid;
    logic                 r_overrun;
    logic                 r_framing_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_word0_a     <= '0;
            r_word1_a     <= '0;
            r_word0_b     <= '0;
            r_word1_b     <= '0;
            r_word_valid  <= 1'b0;
            r_overrun     <= 1'b0;
            r_framing_err <= 1'b0;
        end else begin
            // Flag sets later in this block override the clear.
            if (err_clr) begin
                r_overrun     <= 1'b0;
                r_framing_err <= 1'b0;
            end
            if (r_word_valid && word_ready) begin
                r_word_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_d_start) begin
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_d_start) begin
                        r_framing_err <= 1'b1;
                    end else if (w_done) begin
                        r_state <= ST_DELIVER;
                    end
                end
                ST_DELIVER: begin
                    if (!r_word_valid || word_ready) begin
                        r_word0_a    <= r_sh0_a;
                        r_word1_a    <= r_sh1_a;
                        r_word0_b    <= r_sh0_b;
                        r_word1_b    <= r_sh1_b;
                        r_word_valid <= 1'b1;
                    end else begin
                        r_overrun <= 1'b1;
                    end
                    r_state <= w_d_start ? ST_SHIFT : ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign word0_a     = r_word0_a;
    assign word1_a     = r_word1_a;
`ifdef CIPO_DDR_EN
    assign word0_b     = r_word0_b;
    assign word1_b     = r_word1_b;
`else
    assign word0_b     = '0;
    assign word1_b     = '0;
`endif
    assign word_valid  = r_word_valid;
    assign overrun     = r_overrun;
    assign framing_err = r_framing_err;

endmodule
`default_nettype wire
